// File: rtl/dram_bank_model_if.sv
// dram_bank_model_if: command/response bundle between a DRAM controller (master)
// and the bank model (slave).
interface dram_bank_model_if #(
  parameter int DATA_WIDTH   = 1,
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8
);
  logic [1:0]              cmd;
  logic [NUM_OF_BANKS-1:0] bank_sel;
  logic [NUM_OF_ROWS-1:0]  row_sel;
  logic [NUM_OF_COLS-1:0]  col_sel;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic                    err_flag;
  logic [2:0]              err_code;
  logic [NUM_OF_BANKS-1:0] bank_open;

  modport master (
    output cmd, bank_sel, row_sel, col_sel, wr_data,
    input  rd_data, rd_valid, err_flag, err_code, bank_open
  );

  modport slave (
    input  cmd, bank_sel, row_sel, col_sel, wr_data,
    output rd_data, rd_valid, err_flag, err_code, bank_open
  );
endinterface

// File: rtl/dram_bank_model.sv
// dram_bank_model: cycle-level DRAM device responder with per-bank open-row tracking.
// Optional macro DRAM_TRCD_CHECK_EN enables per-bank ACT-to-RD/WR (tRCD) enforcement.
module dram_bank_model #(
  parameter int DATA_WIDTH   = 1,
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int CAS_LAT      = 2,
  parameter int T_RCD        = 3
) (
  input logic              clk,
  input logic              rst,
  dram_bank_model_if.slave bus
);
  localparam int BANK_W    = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1;
  localparam int ROW_W     = (NUM_OF_ROWS > 1) ? $clog2(NUM_OF_ROWS) : 1;
  localparam int COL_W     = (NUM_OF_COLS > 1) ? $clog2(NUM_OF_COLS) : 1;
  localparam int MEM_DEPTH = NUM_OF_BANKS * NUM_OF_ROWS * NUM_OF_COLS;
  localparam int ADDR_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] CMD_PRE = 2'b00;
  localparam logic [1:0] CMD_ACT = 2'b01;
  localparam logic [1:0] CMD_RD  = 2'b10;
  localparam logic [1:0] CMD_WR  = 2'b11;

  localparam logic [2:0] ERR_SEL  = 3'd1;
  localparam logic [2:0] ERR_IDLE = 3'd2;
  localparam logic [2:0] ERR_OPEN = 3'd3;

  typedef enum logic {IDLE, OPEN} bank_state_e;

  if (CAS_LAT < 1 || CAS_LAT > 7 || T_RCD < 1) begin : g_paramCheck
    $error("dram_bank_model: CAS_LAT must be 1..7 and T_RCD at least 1");
  end

  bank_state_e           r_state   [NUM_OF_BANKS];
  logic [ROW_W-1:0]      r_openRow [NUM_OF_BANKS];
  logic                  r_errFlag;
  logic [2:0]            r_errCode;
  logic [CAS_LAT-1:0]    r_rdValid;
  logic [DATA_WIDTH-1:0] r_rdData  [CAS_LAT];
  logic [DATA_WIDTH-1:0] r_mem     [MEM_DEPTH] = '{default: '0};

`ifdef DRAM_TRCD_CHECK_EN
  localparam int         RCD_W    = $clog2(T_RCD + 1);
  localparam logic [2:0] ERR_TRCD = 3'd4;
  logic [RCD_W-1:0]      r_rcdCnt [NUM_OF_BANKS];
`endif

  logic                    w_bankOneHot;
  logic                    w_rowOneHot;
  logic                    w_colOneHot;
  logic [BANK_W-1:0]       w_bankIdx;
  logic [ROW_W-1:0]        w_rowIdx;
  logic [COL_W-1:0]        w_colIdx;
  logic [ROW_W-1:0]        w_curRow;
  logic [ADDR_W-1:0]       w_memAddr;
  logic [DATA_WIDTH-1:0]   w_memRd;
  logic                    w_doPre;
  logic                    w_doAct;
  logic                    w_doRd;
  logic                    w_doWr;
  logic                    w_errValid;
  logic [2:0]              w_errCode;
  logic [NUM_OF_BANKS-1:0] w_bankOpen;

  assign w_bankOneHot = (bus.bank_sel != '0) &&
                        ((bus.bank_sel & (bus.bank_sel - NUM_OF_BANKS'(1))) == '0);
  assign w_rowOneHot  = (bus.row_sel != '0) &&
                        ((bus.row_sel & (bus.row_sel - NUM_OF_ROWS'(1))) == '0);
  assign w_colOneHot  = (bus.col_sel != '0) &&
                        ((bus.col_sel & (bus.col_sel - NUM_OF_COLS'(1))) == '0);

  // OR-reduction encoders; results are only trusted once the one-hot check passes
  always_comb begin
    w_bankIdx = '0;
    w_rowIdx  = '0;
    w_colIdx  = '0;
    for (int i = 0; i < NUM_OF_BANKS; i++)
      if (bus.bank_sel[i]) w_bankIdx = w_bankIdx | BANK_W'(i);
    for (int i = 0; i < NUM_OF_ROWS; i++)
      if (bus.row_sel[i]) w_rowIdx = w_rowIdx | ROW_W'(i);
    for (int i = 0; i < NUM_OF_COLS; i++)
      if (bus.col_sel[i]) w_colIdx = w_colIdx | COL_W'(i);
  end

  assign w_curRow  = r_openRow[w_bankIdx];
  assign w_memAddr = ADDR_W'(w_bankIdx) * ADDR_W'(NUM_OF_ROWS * NUM_OF_COLS) +
                     ADDR_W'(w_curRow) * ADDR_W'(NUM_OF_COLS) + ADDR_W'(w_colIdx);
  assign w_memRd   = r_mem[w_memAddr];

  always_comb begin
    w_doPre    = 1'b0;
    w_doAct    = 1'b0;
    w_doRd     = 1'b0;
    w_doWr     = 1'b0;
    w_errValid = 1'b0;
    w_errCode  = '0;
    case (bus.cmd)
      CMD_PRE: w_doPre = (bus.bank_sel != '0);
      CMD_ACT: begin
        if (!(w_bankOneHot && w_rowOneHot)) begin
          w_errValid = 1'b1;
          w_errCode  = ERR_SEL;
        end else if (r_state[w_bankIdx] == OPEN) begin
          w_errValid = 1'b1;
          w_errCode  = ERR_OPEN;
        end else begin
          w_doAct = 1'b1;
        end
      end
      CMD_RD, CMD_WR: begin
        if (!(w_bankOneHot && w_colOneHot)) begin
          w_errValid = 1'b1;
          w_errCode  = ERR_SEL;
        end else if (r_state[w_bankIdx] == IDLE) begin
          w_errValid = 1'b1;
          w_errCode  = ERR_IDLE;
`ifdef DRAM_TRCD_CHECK_EN
        end else if (r_rcdCnt[w_bankIdx] != '0) begin
          w_errValid = 1'b1;
          w_errCode  = ERR_TRCD;
`endif
        end else if (bus.cmd == CMD_RD) begin
          w_doRd = 1'b1;
        end else begin
          w_doWr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Per-bank open/idle state, latched row, and error reporting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
        r_state[b]   <= IDLE;
        r_openRow[b] <= '0;
`ifdef DRAM_TRCD_CHECK_EN
        r_rcdCnt[b]  <= '0;
`endif
      end
      r_errFlag <= 1'b0;
      r_errCode <= '0;
    end else begin
      r_errFlag <= w_errValid;
      if (w_errValid) r_errCode <= w_errCode;
`ifdef DRAM_TRCD_CHECK_EN
      for (int b = 0; b < NUM_OF_BANKS; b++)
        if (r_rcdCnt[b] != '0) r_rcdCnt[b] <= r_rcdCnt[b] - RCD_W'(1);
`endif
      if (w_doPre) begin
        for (int b = 0; b < NUM_OF_BANKS; b++) begin
          if (bus.bank_sel[b]) begin
            r_state[b] <= IDLE;
`ifdef DRAM_TRCD_CHECK_EN
            r_rcdCnt[b] <= '0;
`endif
          end
        end
      end
      if (w_doAct) begin
        r_state[w_bankIdx]   <= OPEN;
        r_openRow[w_bankIdx] <= w_rowIdx;
`ifdef DRAM_TRCD_CHECK_EN
        // T_RCD-1 so that a RD/WR exactly T_RCD cycles after ACT is the first legal one
        r_rcdCnt[w_bankIdx]  <= RCD_W'(T_RCD - 1);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_doWr) r_mem[w_memAddr] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdValid <= '0;
      for (int i = 0; i < CAS_LAT; i++) r_rdData[i] <= '0;
    end else begin
      r_rdValid[0] <= w_doRd;
      r_rdData[0]  <= w_doRd ? w_memRd : '0;
      for (int i = 1; i < CAS_LAT; i++) begin
        r_rdValid[i] <= r_rdValid[i-1];
        r_rdData[i]  <= r_rdData[i-1];
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_OF_BANKS; b++) begin
`ifdef DRAM_TRCD_CHECK_EN
      w_bankOpen[b] = (r_state[b] == OPEN) && (r_rcdCnt[b] == '0);
`else
      w_bankOpen[b] = (r_state[b] == OPEN);
`endif
    end
  end

  assign bus.rd_data   = r_rdData[CAS_LAT-1];
  assign bus.rd_valid  = r_rdValid[CAS_LAT-1];
  assign bus.err_flag  = r_errFlag;
  assign bus.err_code  = r_errCode;
  assign bus.bank_open = w_bankOpen;
endmodule
